// File: rtl/fruit_catch_ctrl.sv
// Per-frame fruit collision scheduler: scans one slot per clock against the latched
// character position, pulses hits/despawns and keeps a saturating score. Optional HIT_COMBO_EN.
module fruit_catch_ctrl #(
  parameter int NUM_FRUIT = 7,
  parameter int COORD_W   = 7,
  parameter int SCORE_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             char_x,
  input  logic [COORD_W-1:0]             char_y,
  input  logic [NUM_FRUIT*COORD_W-1:0]   fruit_x,
  input  logic [NUM_FRUIT*COORD_W-1:0]   fruit_y,
  input  logic [NUM_FRUIT*3-1:0]         fruit_colour,
  input  logic [NUM_FRUIT-1:0]           fruit_valid,
  output logic                           busy,
  output logic                           hit_valid,
  output logic [$clog2(NUM_FRUIT)-1:0]   hit_idx,
  output logic [2:0]                     hit_colour,
  output logic [NUM_FRUIT-1:0]           clear_mask,
  output logic                           scan_done,
  output logic [SCORE_W-1:0]             score
);

  localparam int IDX_W = $clog2(NUM_FRUIT);
  localparam int EXT_W = SCORE_W + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRUIT - 1);

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;

  logic [COORD_W-1:0] slot_x;
  logic [COORD_W-1:0] slot_y;
  logic [2:0]         slot_colour;
  logic               slot_valid;
  logic               slot_hit;
  logic               last_slot;

  logic signed [EXT_W-1:0] delta;
  logic signed [EXT_W-1:0] bonus;
  logic signed [EXT_W-1:0] sum;
  logic [SCORE_W-1:0]      score_next;

  // Single shared compare datapath, steered by the scan index
  always_comb begin
    slot_x      = fruit_x[int'(idx)*COORD_W +: COORD_W];
    slot_y      = fruit_y[int'(idx)*COORD_W +: COORD_W];
    slot_colour = fruit_colour[int'(idx)*3 +: 3];
    slot_valid  = fruit_valid[idx];
    slot_hit    = slot_valid && (slot_x == cx) && (slot_y == cy) && (slot_colour != 3'b111);
    last_slot   = (idx == LAST_IDX);
  end

`ifdef HIT_COMBO_EN
  logic had_hit;

  // Remembers whether this scan already scored a hit, so later positive hits earn a bonus
  always_ff @(posedge clk) begin
    if (reset) begin
      had_hit <= 1'b0;
    end else if (state == IDLE && frame_tick) begin
      had_hit <= 1'b0;
    end else if (state == HIT) begin
      had_hit <= 1'b1;
    end
  end
`endif

  always_comb begin
    case (hit_colour)
      3'b000:  delta = EXT_W'(1);
      3'b001:  delta = EXT_W'(2);
      3'b010:  delta = EXT_W'(3);
      3'b011:  delta = EXT_W'(4);
      3'b100:  delta = EXT_W'(-1);
      3'b101:  delta = EXT_W'(5);
      3'b110:  delta = EXT_W'(-2);
      default: delta = '0;
    endcase
    bonus = '0;
`ifdef HIT_COMBO_EN
    if (had_hit && !delta[EXT_W-1] && (delta != '0)) begin
      bonus = EXT_W'(1);
    end
`endif
    sum = $signed({2'b00, score}) + delta + bonus;
    // Sign bit means underflow; bit SCORE_W set on a non-negative sum means overflow
    if (sum[EXT_W-1]) begin
      score_next = '0;
    end else if (sum[SCORE_W]) begin
      score_next = '1;
    end else begin
      score_next = sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cx         <= '0;
      cy         <= '0;
      busy       <= 1'b0;
      hit_valid  <= 1'b0;
      hit_idx    <= '0;
      hit_colour <= '0;
      clear_mask <= '0;
      scan_done  <= 1'b0;
      score      <= '0;
    end else begin
      hit_valid  <= 1'b0;
      clear_mask <= '0;
      scan_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            cx    <= char_x;
            cy    <= char_y;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (slot_hit) begin
            hit_valid  <= 1'b1;
            hit_idx    <= idx;
            hit_colour <= slot_colour;
            clear_mask <= NUM_FRUIT'(1) << idx;
            state      <= HIT;
          end else if (last_slot) begin
            scan_done <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        HIT: begin
          score <= score_next;
          if (last_slot) begin
            scan_done <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_catch_ctrl.sv
// Self-checking bench for fruit_catch_ctrl: a frame model pushes expected hits into a
// queue, observed hits are popped against it. Honours HIT_COMBO_EN if defined.
module tb_fruit_catch_ctrl;
  localparam int NF = 7;
  localparam int CW = 7;
  localparam int SW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_tick;
  logic [CW-1:0]     char_x;
  logic [CW-1:0]     char_y;
  logic [NF*CW-1:0]  fruit_x;
  logic [NF*CW-1:0]  fruit_y;
  logic [NF*3-1:0]   fruit_colour;
  logic [NF-1:0]     fruit_valid;
  logic              busy;
  logic              hit_valid;
  logic [2:0]        hit_idx;
  logic [2:0]        hit_colour;
  logic [NF-1:0]     clear_mask;
  logic              scan_done;
  logic [SW-1:0]     score;

  typedef struct {
    logic [2:0]    idx;
    logic [2:0]    col;
    logic [NF-1:0] mask;
    int            cycle;
    logic [SW-1:0] score;
  } hit_t;

  hit_t exp_q[$];
  hit_t obs_q[$];
  int   exp_done;
  int   obs_done;
  int   model_score;
  int   tests_run;
  int   tests_failed;
  logic obs_busy1;
  logic obs_busy_after;

  logic [CW-1:0] fx[NF];
  logic [CW-1:0] fy[NF];
  logic [2:0]    fc[NF];
  logic          fv[NF];

  fruit_catch_ctrl #(.NUM_FRUIT(NF), .COORD_W(CW), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .char_x(char_x), .char_y(char_y),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_colour(fruit_colour), .fruit_valid(fruit_valid),
    .busy(busy), .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_colour(hit_colour),
    .clear_mask(clear_mask), .scan_done(scan_done), .score(score)
  );

  always #5 clk = ~clk;

  always_comb begin
    fruit_x = '0;
    fruit_y = '0;
    fruit_colour = '0;
    fruit_valid = '0;
    for (int i = 0; i < NF; i++) begin
      fruit_x[i*CW +: CW] = fx[i];
      fruit_y[i*CW +: CW] = fy[i];
      fruit_colour[i*3 +: 3] = fc[i];
      fruit_valid[i] = fv[i];
    end
  end

  function automatic int delta_of(input logic [2:0] c);
    case (c)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 3;
      3'b011: return 4;
      3'b100: return -1;
      3'b101: return 5;
      3'b110: return -2;
      default: return 0;
    endcase
  endfunction

  task automatic clear_slots();
    for (int i = 0; i < NF; i++) begin
      fx[i] = CW'(100 + i);
      fy[i] = CW'(110 + i);
      fc[i] = 3'b000;
      fv[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y, input logic [2:0] c, input logic v);
    fx[i] = CW'(x);
    fy[i] = CW'(y);
    fc[i] = c;
    fv[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_score = 0;
  endtask

  // Reference frame model: pushes every expected hit with its cycle and resulting score
  task automatic model_frame(input int cx, input int cy);
    int   hits;
    int   s;
    int   d;
    hit_t e;
    hits = 0;
    for (int i = 0; i < NF; i++) begin
      if (fv[i] && fx[i] == CW'(cx) && fy[i] == CW'(cy) && fc[i] != 3'b111) begin
        d = delta_of(fc[i]);
        s = model_score + d;
`ifdef HIT_COMBO_EN
        if (d > 0 && hits > 0) s = s + 1;
`endif
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        model_score = s;
        e.idx = 3'(i);
        e.col = fc[i];
        e.mask = NF'(1) << i;
        e.cycle = i + 2 + hits;
        e.score = SW'(s);
        exp_q.push_back(e);
        hits++;
      end
    end
    exp_done = NF + hits + 1;
  endtask

  // Drives one frame tick and records what the DUT produces, cycle 0 being the tick cycle
  task automatic run_frame(input int cx, input int cy, input int retick_cycle);
    hit_t h;
    bit   pend;
    obs_q.delete();
    obs_done = -1;
    obs_busy1 = 1'bx;
    obs_busy_after = 1'bx;
    pend = 0;
    @(negedge clk);
    char_x = CW'(cx);
    char_y = CW'(cy);
    frame_tick = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      frame_tick = (c == retick_cycle);
      if (c == 1) obs_busy1 = busy;
      if (pend) begin
        h.score = score;
        obs_q.push_back(h);
        pend = 0;
      end
      if (obs_done >= 0) begin
        obs_busy_after = busy;
        break;
      end
      if (hit_valid) begin
        h.idx = hit_idx;
        h.col = hit_colour;
        h.mask = clear_mask;
        h.cycle = c;
        pend = 1;
      end
      if (scan_done) obs_done = c;
    end
    frame_tick = 1'b0;
  endtask

  task automatic single_hit(input logic [2:0] col);
    clear_slots();
    set_slot(0, 3, 3, col, 1'b1);
    model_frame(3, 3);
    run_frame(3, 3, -1);
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    char_x = '0;
    char_y = '0;
    clear_slots();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, hit_valid, hit_idx, hit_colour, clear_mask, scan_done, score} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b hv=%b idx=%0d col=%b mask=%b done=%b score=%0d, expected all 0",
               busy, hit_valid, hit_idx, hit_colour, clear_mask, scan_done, score);
    end
    reset = 1'b0;
    model_score = 0;
  endtask

  task automatic test_empty_frame();
    clear_slots();
    model_frame(5, 5);
    run_frame(5, 5, -1);
    tests_run++;
    if (obs_q.size() != 0 || obs_done != 8 || exp_done != 8) begin
      tests_failed++;
      $display("[TB] FAIL empty_frame: got hits=%0d done_cycle=%0d, expected hits=0 done_cycle=8",
               obs_q.size(), obs_done);
    end
    tests_run++;
    if (score !== 8'd0 || obs_busy1 !== 1'b1 || obs_busy_after !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL empty_busy_score: got score=%0d busy1=%b busy_after=%b, expected 0/1/0",
               score, obs_busy1, obs_busy_after);
    end
    exp_q.delete();
  endtask

  task automatic test_hits();
    hit_t e;
    hit_t o;
    int   cx;
    int   cy;
    for (int s = 0; s < 6; s++) begin
      clear_slots();
      cx = 5;
      cy = 5;
      case (s)
        0: begin
          do_reset();
          set_slot(3, 5, 5, 3'b010, 1'b1);
          set_slot(1, 5, 6, 3'b000, 1'b1);
          set_slot(4, 6, 5, 3'b000, 1'b1);
        end
        1: begin
          do_reset();
          cx = 9;
          cy = 9;
          set_slot(0, 9, 9, 3'b101, 1'b1);
          set_slot(6, 9, 9, 3'b000, 1'b1);
          set_slot(2, 9, 8, 3'b001, 1'b1);
        end
        2: begin
          set_slot(2, 5, 5, 3'b111, 1'b1);
          set_slot(4, 5, 5, 3'b001, 1'b0);
        end
        default: begin
          cx = 1;
          cy = 1;
          for (int i = 0; i < NF; i++)
            set_slot(i, $urandom_range(0, 2), $urandom_range(0, 2), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
        end
      endcase
      model_frame(cx, cy);
      run_frame(cx, cy, -1);
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("[TB] FAIL hit_count s%0d: got %0d hits, expected %0d", s, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        tests_run++;
        if (o.idx !== e.idx || o.col !== e.col || o.mask !== e.mask || o.cycle != e.cycle || o.score !== e.score) begin
          tests_failed++;
          $display("[TB] FAIL hit_event s%0d: got idx=%0d col=%b mask=%b cyc=%0d score=%0d, expected idx=%0d col=%b mask=%b cyc=%0d score=%0d",
                   s, o.idx, o.col, o.mask, o.cycle, o.score, e.idx, e.col, e.mask, e.cycle, e.score);
        end
      end
      exp_q.delete();
      tests_run++;
      if (obs_done != exp_done || obs_busy1 !== 1'b1 || obs_busy_after !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL scan_done s%0d: got cycle=%0d busy1=%b busy_after=%b, expected cycle=%0d 1/0",
                 s, obs_done, obs_busy1, obs_busy_after, exp_done);
      end
      tests_run++;
      if (score !== SW'(model_score)) begin
        tests_failed++;
        $display("[TB] FAIL frame_score s%0d: got %0d, expected %0d", s, score, model_score);
      end
    end
  endtask

  task automatic test_saturation();
    int guard;
    do_reset();
    single_hit(3'b000);
    single_hit(3'b110);
    tests_run++;
    if (score !== 8'd0 || model_score != 0) begin
      tests_failed++;
      $display("[TB] FAIL sat_low: got %0d, expected 0", score);
    end
    guard = 0;
    while (model_score != 254 && guard < 80) begin
      if (254 - model_score >= 5) single_hit(3'b101);
      else single_hit(3'(254 - model_score - 1));
      guard++;
    end
    tests_run++;
    if (score !== 8'd254) begin
      tests_failed++;
      $display("[TB] FAIL sat_ramp: got %0d, expected 254", score);
    end
    single_hit(3'b011);
    tests_run++;
    if (score !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL sat_high: got %0d, expected 255", score);
    end
    single_hit(3'b101);
    tests_run++;
    if (score !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: got %0d, expected 255", score);
    end
  endtask

  task automatic test_retick();
    do_reset();
    clear_slots();
    set_slot(2, 7, 8, 3'b001, 1'b1);
    set_slot(5, 7, 8, 3'b011, 1'b1);
    model_frame(7, 8);
    run_frame(7, 8, 3);
    tests_run++;
    if (obs_q.size() != 2 || obs_done != exp_done || obs_busy_after !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retick_midscan: got hits=%0d done=%0d busy_after=%b, expected hits=2 done=%0d busy_after=0",
               obs_q.size(), obs_done, obs_busy_after, exp_done);
    end
    tests_run++;
    if (score !== SW'(model_score)) begin
      tests_failed++;
      $display("[TB] FAIL retick_score: got %0d, expected %0d", score, model_score);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    clear_slots();
    set_slot(6, 2, 2, 3'b000, 1'b1);
    model_frame(2, 2);
    run_frame(2, 2, exp_done);
    tests_run++;
    if (obs_done != exp_done || obs_busy_after !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tick_in_done: got done=%0d busy_after=%b, expected done=%0d busy_after=0",
               obs_done, obs_busy_after, exp_done);
    end
    exp_q.delete();
    model_frame(2, 2);
    run_frame(2, 2, -1);
    tests_run++;
    if (obs_q.size() != 1 || obs_done != exp_done || score !== SW'(model_score)) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: got hits=%0d done=%0d score=%0d, expected hits=1 done=%0d score=%0d",
               obs_q.size(), obs_done, score, exp_done, model_score);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    bit seen;
    bit bad;
    do_reset();
    clear_slots();
    set_slot(3, 4, 4, 3'b101, 1'b1);
    set_slot(5, 4, 4, 3'b000, 1'b1);
    @(negedge clk);
    char_x = 7'd4;
    char_y = 7'd4;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (hit_valid) seen = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL abort_hit_seen: got no hit_valid within 20 cycles, expected one");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_score = 0;
    tests_run++;
    if (busy !== 1'b0 || score !== 8'd0 || hit_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got busy=%b score=%0d hv=%b, expected 0/0/0", busy, score, hit_valid);
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (scan_done !== 1'b0 || hit_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: got activity after aborted frame, expected none");
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_empty_frame();
    test_hits();
    test_saturation();
    test_retick();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
